assoc_cache_ctrl: RTL and testbench

- Parametrised 2-way set-associative, read-only cache controller with per-set LRU replacement; next generation of the team's direct-mapped cache top.
- Sits between a word-addressed requester (CPU or testbench sweep) and a block-wide main-memory model.
- Replaces the fixed "done" pulse with a valid/ready request handshake and a variable-latency memory handshake.
- Exposes hit and access counters for hit-rate measurement.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_set_array.sv | 64 ++++++
 rtl/assoc_cache_ctrl.sv | 177 +++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the 2-way set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int words, input int sets);
    return addr_w - $clog2(words) - $clog2(sets);
  endfunction

  // Line and tag types of the default geometry (15-bit address, 4 x 32-bit words, 128 sets).
  localparam int DEF_LINE_W = 32 * 4;
  localparam int DEF_TAG_W  = tag_w(15, 4, 128);
  typedef logic [DEF_LINE_W-1:0] line_t;
  typedef logic [DEF_TAG_W-1:0]  tag_t;

endpackage

// File: rtl/cache_set_array.sv
// Tag/valid/data/LRU storage for a 2-way cache, one combinational read port per set.
// Latency: reads are combinational; writes and LRU updates land on the next clock edge.
// Backpressure: none, the controller owns all sequencing.
module cache_set_array
  import cache_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 128,
  localparam int IDX_W  = idx_w(SETS),
  localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS),
  localparam int LINE_W = DATA_W * WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [1:0]        rd_valid,
  output logic [TAG_W-1:0]  rd_tag0,
  output logic [TAG_W-1:0]  rd_tag1,
  output logic [LINE_W-1:0] rd_line0,
  output logic [LINE_W-1:0] rd_line1,
  output logic              rd_lru,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_way,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              lru_en,
  input  logic [IDX_W-1:0]  lru_idx,
  input  logic              lru_val
);

  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_mem  [2][SETS];
  logic [LINE_W-1:0]    data_mem [2][SETS];

  // Only valid and LRU bits need clearing; stale tag/data behind a clear valid is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (wr_en)  valid_q[wr_way][wr_idx] <= 1'b1;
      if (lru_en) lru_q[lru_idx]          <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_way][wr_idx]  <= wr_tag;
      data_mem[wr_way][wr_idx] <= wr_line;
    end
  end

  assign rd_valid = {valid_q[1][rd_idx], valid_q[0][rd_idx]};
  assign rd_tag0  = tag_mem[0][rd_idx];
  assign rd_tag1  = tag_mem[1][rd_idx];
  assign rd_line0 = data_mem[0][rd_idx];
  assign rd_line1 = data_mem[1][rd_idx];
  assign rd_lru   = lru_q[rd_idx];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative read-only cache controller with per-set LRU and hit/access counters.
// Latency: hit responds 2 cycles after acceptance; miss responds 1 cycle after mem_ack.
// Backpressure: req_ready only in IDLE, so one request in flight; memory side waits on mem_ack.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 128,
  parameter int CNT_W  = 32,
  localparam int OFF_W  = off_w(WORDS),
  localparam int IDX_W  = idx_w(SETS),
  localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS),
  localparam int BLK_W  = ADDR_W - OFF_W,
  localparam int LINE_W = DATA_W * WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_rd,
  output logic [BLK_W-1:0]  mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_line,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  if (ADDR_W <= OFF_W + IDX_W) begin : g_bad_addr_w
    $error("assoc_cache_ctrl: ADDR_W must exceed log2(WORDS) + log2(SETS)");
  end
  if (WORDS < 2) begin : g_bad_words
    $error("assoc_cache_ctrl: WORDS must be at least 2");
  end

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          resp_data_q;
  logic                       resp_hit_q;
  logic [CNT_W-1:0]           hit_cnt_q, acc_cnt_q;

  logic [OFF_W-1:0]           off_q;
  logic [IDX_W-1:0]           idx_q;
  logic [TAG_W-1:0]           tag_q;
  logic [1:0]                 rd_valid;
  logic [TAG_W-1:0]           rd_tag0, rd_tag1;
  logic [LINE_W-1:0]          rd_line0, rd_line1;
  logic                       rd_lru;
  logic                       hit0, hit1, victim;
  logic                       wr_en, lru_en, lru_val;
  logic                       ld_resp, ld_hit, acc_inc, hit_inc;
  logic [LINE_W-1:0]          sel_line;
  logic [WORDS-1:0][DATA_W-1:0] sel_words;

  assign off_q = addr_q[OFF_W-1:0];
  assign idx_q = addr_q[OFF_W +: IDX_W];
  assign tag_q = addr_q[ADDR_W-1 -: TAG_W];

  cache_set_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .SETS   (SETS)
  ) u_sets (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_q),
    .rd_valid (rd_valid),
    .rd_tag0  (rd_tag0),
    .rd_tag1  (rd_tag1),
    .rd_line0 (rd_line0),
    .rd_line1 (rd_line1),
    .rd_lru   (rd_lru),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_way   (victim),
    .wr_tag   (tag_q),
    .wr_line  (mem_line),
    .lru_en   (lru_en),
    .lru_idx  (idx_q),
    .lru_val  (lru_val)
  );

  assign hit0 = rd_valid[0] && (rd_tag0 == tag_q);
  assign hit1 = rd_valid[1] && (rd_tag1 == tag_q);
  // The LRU bit names the way to evict next; empty ways are always filled first.
  assign victim = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd     = 1'b0;
    wr_en      = 1'b0;
    lru_en     = 1'b0;
    lru_val    = 1'b0;
    ld_resp    = 1'b0;
    ld_hit     = 1'b0;
    acc_inc    = 1'b0;
    hit_inc    = 1'b0;
    sel_line   = rd_line0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          acc_inc = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          lru_en   = 1'b1;
          lru_val  = !hit1;
          sel_line = hit1 ? rd_line1 : rd_line0;
          ld_resp  = 1'b1;
          ld_hit   = 1'b1;
          hit_inc  = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          wr_en    = 1'b1;
          lru_en   = 1'b1;
          lru_val  = !victim;
          sel_line = mem_line;
          ld_resp  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_words = sel_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      hit_cnt_q   <= '0;
      acc_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc_inc) begin
        addr_q    <= req_addr;
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
      if (hit_inc) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (ld_resp) begin
        resp_data_q <= sel_words[off_q];
        resp_hit_q  <= ld_hit;
      end
    end
  end

  assign mem_addr     = mem_rd ? addr_q[ADDR_W-1:OFF_W] : '0;
  assign resp_data    = resp_data_q;
  assign resp_hit     = resp_hit_q;
  assign hit_count    = hit_cnt_q;
  assign access_count = acc_cnt_q;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl; a second instance with 4-bit counters runs in lockstep for wrap checks.
module tb_assoc_cache_ctrl;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int SETS   = 128;
  localparam int BLK_W  = ADDR_W - 2;
  localparam int LINE_W = DATA_W * WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_line;

  logic              req_ready, resp_valid, resp_hit, mem_rd;
  logic [DATA_W-1:0] resp_data;
  logic [BLK_W-1:0]  mem_addr;
  logic [31:0]       hit_count, access_count;

  logic              req_ready4, resp_valid4, resp_hit4, mem_rd4;
  logic [DATA_W-1:0] resp_data4;
  logic [BLK_W-1:0]  mem_addr4;
  logic [3:0]        hit_count4, access_count4;

  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] last_data;

  always #5 clk = ~clk;

  assoc_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_line(mem_line), .hit_count(hit_count),
    .access_count(access_count)
  );

  assoc_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready4),
    .resp_valid(resp_valid4), .resp_data(resp_data4), .resp_hit(resp_hit4), .mem_rd(mem_rd4),
    .mem_addr(mem_addr4), .mem_ack(mem_ack), .mem_line(mem_line), .hit_count(hit_count4),
    .access_count(access_count4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Memory model: every word holds its own word address.
  function automatic logic [LINE_W-1:0] line_of(input int blk);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*DATA_W +: DATA_W] = DATA_W'(blk * WORDS + i);
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    last_data = '0;
  endtask

  // One request; the memory answers dly cycles after mem_rd first rises.
  task automatic do_access(input int addr, input int dly, input bit exp_hit);
    int               cyc;
    int               k;
    logic [BLK_W-1:0] blk;
    blk = BLK_W'(addr >> 2);
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    chk("ready4", req_ready4, 1);
    chk("resp_valid_idle", resp_valid, 0);
    chk("resp_data_hold", resp_data, last_data);
    req_valid = 1'b1;
    req_addr  = ADDR_W'(addr);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    k   = 0;
    while (!resp_valid && cyc < 200) begin
      if (mem_rd) begin
        chk("mem_addr", mem_addr, blk);
        chk("mem_addr4", {mem_rd4, mem_addr4}, {1'b1, blk});
        if (k == dly) begin
          mem_ack  = 1'b1;
          mem_line = line_of(addr >> 2);
        end
        k++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      cyc++;
    end
    chk("resp_valid", resp_valid, 1);
    chk("latency", cyc, exp_hit ? 2 : 3 + dly);
    chk("resp_hit", resp_hit, exp_hit);
    chk("resp_data", resp_data, DATA_W'(addr));
    chk("mem_rd_after", mem_rd, 0);
    chk("resp4", {resp_valid4, resp_hit4, resp_data4}, {1'b1, exp_hit, DATA_W'(addr)});
    last_data = DATA_W'(addr);
  endtask

  int lru_addr [6] = '{0, 512, 0, 1024, 0, 512};
  bit lru_hit  [6] = '{0, 0, 1, 0, 1, 0};

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_line  = '0;
    last_data = '0;

    do_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp", {resp_hit, resp_data}, 0);
    chk("rst_counts", {hit_count, access_count}, 0);

    // Cold miss with a 5-cycle memory, then a hit in the same block.
    do_access(1024, 5, 0);
    do_access(1025, 0, 1);
    chk("cold_counts", {hit_count, access_count}, {32'd1, 32'd2});

    // LRU conflict in set 0.
    do_reset();
    for (int i = 0; i < 6; i++) do_access(lru_addr[i], 1, lru_hit[i]);
    chk("lru_hits", hit_count, 2);
    chk("lru_accesses", access_count, 6);

    // Sequential sweep from cold.
    do_reset();
    for (int a = 1024; a <= 9023; a++) do_access(a, 0, (a % 4) != 0);
    chk("sweep_accesses", access_count, 8000);
    chk("sweep_hits", hit_count, 6000);

    // Spurious ack in IDLE must be ignored.
    @(negedge clk);
    mem_ack  = 1'b1;
    mem_line = '1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("spur_resp_valid", resp_valid, 0);
    chk("spur_ready", req_ready, 1);
    chk("spur_mem_rd", mem_rd, 0);
    do_access(9023, 0, 1);
    chk("spur_counts", {hit_count, access_count}, {32'd6001, 32'd8001});

    // Random memory latency on fresh blocks.
    for (int i = 0; i < 8; i++) do_access(16384 + 4 * i, int'($urandom_range(0, 20)), 0);
    chk("rand_counts", {hit_count, access_count}, {32'd6001, 32'd8009});

    // Reset while waiting on mem_ack.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = ADDR_W'(20000);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("miss_mem_rd", mem_rd, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_counts", {hit_count, access_count}, 0);
    chk("abort_resp_data", resp_data, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", {resp_valid, mem_rd}, 0);
    end
    rst       = 1'b0;
    last_data = '0;
    do_access(20000, 2, 0);
    chk("abort_refetch_counts", {hit_count, access_count}, {32'd0, 32'd1});

    // Counter wrap on the 4-bit instance.
    do_reset();
    do_access(2000, 3, 0);
    for (int i = 0; i < 17; i++) do_access(2000 + (i % 4), 0, 1);
    chk("wrap_hits32", hit_count, 17);
    chk("wrap_acc32", access_count, 18);
    chk("wrap_hits4", hit_count4, 1);
    chk("wrap_acc4", access_count4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
